gpo_seq: RTL and testbench
==========================

GPO_SEQ -- requirements
Module: gpo_seq

Interface
REQ-001 SHALL have parameter W, default 8, meaning width of the sequenced output port.
REQ-002 SHALL have parameter DEPTH, fixed at 8, meaning number of pattern-table steps.
REQ-003 SHALL have port clk, input, 1, meaning the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, meaning asynchronous active-low reset.
REQ-005 SHALL have port cs, input, 1, meaning slot chip select.
REQ-006 SHALL have port read, input, 1, meaning slot read strobe.
REQ-007 SHALL have port write, input, 1, meaning slot write strobe.
REQ-008 SHALL have port addr, input, 5, meaning slot register address.
REQ-009 SHALL have port wr_data, input, 32, meaning slot write data.
REQ-010 SHALL have port rd_data, output, 32, meaning slot read data.
REQ-011 SHALL have port dout, output, W, meaning the registered sequenced output pattern.

Function
REQ-012 SHALL accept a register write only in a cycle with cs && write; read and write strobes SHALL have no side effects.
REQ-013 SHALL map addr 0x00-0x07 to step entries: wr_data[W-1:0] is the pattern and wr_data[31:16] is the dwell in ticks; a dwell of 0 SHALL behave as 1.
REQ-014 SHALL map addr 0x08 to CTRL: bit0 START (write-1 pulse), bit1 STOP (write-1 pulse), bit2 LOOP (stored), bits[6:4] LAST (stored last-step index).
REQ-015 SHALL map addr 0x09 to PRESC[15:0]; one tick SHALL occur every PRESC+1 clk cycles while in RUN.
REQ-016 SHALL map addr 0x0A to read-only STATUS: bit0 BUSY, bit1 DONE (sticky), bits[6:4] current step index.
REQ-017 SHALL map addr 0x0B to IDLE_VAL[W-1:0], the value of dout in IDLE.
REQ-018 SHALL drive rd_data combinationally from addr: table entries, CTRL (stored bits, pulse bits read 0), PRESC, STATUS and IDLE_VAL zero-extended; unmapped addresses SHALL read 0.
REQ-019 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-020 SHALL on START from any state enter RUN at step 0, load the dwell counter from entry 0, restart the prescaler, clear DONE, and present pattern[0] on dout at the next clock edge.
REQ-021 SHALL in RUN decrement the dwell counter on each tick; on a tick with counter==1: if step<LAST, advance the step, reload the dwell and update dout; if step==LAST and LOOP=1, go to step 0; if step==LAST and LOOP=0, enter DONE.
REQ-022 SHALL hold each step on dout for exactly max(dwell,1)*(PRESC+1) clk cycles.
REQ-023 SHALL in DONE hold the last pattern on dout, with BUSY=0 and DONE=1.
REQ-024 SHALL on STOP enter IDLE and drive IDLE_VAL on dout from the next edge; DONE SHALL remain unchanged.
REQ-025 SHALL give STOP priority when START and STOP are written together.
REQ-026 SHALL treat a START write while in RUN as a restart at step 0.
REQ-027 SHALL apply table writes during RUN at the next step entry; the active step's pattern and dwell are latched at entry.
REQ-028 SHALL update IDLE_VAL on dout within one cycle when written in IDLE.
REQ-029 SHALL assert BUSY exactly in RUN.

Reset
REQ-030 SHALL, while reset_n=0, asynchronously clear the FSM to IDLE and clear all table entries, CTRL, PRESC, IDLE_VAL, counters, DONE and dout to 0.
REQ-031 SHALL abort any sequence when reset_n is asserted mid-RUN, with no further tick or step update until a new START.

Structure
REQ-032 SHALL place the register address constants, the CTRL and STATUS bit positions and the FSM state enum in a shared package, gpo_seq_pkg.
REQ-033 SHALL implement the prescaler in one sub-module, gpo_tick_gen, with inputs clk, reset_n, clear and presc[15:0] and a one-cycle tick output.

Verification
REQ-034 SHALL cover a basic sequence: PRESC=0, entries 0/1 = 0xA5/dwell 2 and 0x3C/dwell 3, LAST=1, LOOP=0, START -> dout 0xA5 for 2 cycles, then 0x3C for 3 cycles, then DONE with dout 0x3C and STATUS=0x012.
REQ-035 SHALL cover looping: PRESC=3, LAST=0, entry 0 dwell 1, LOOP=1 -> BUSY stays 1, step stays 0 and tick period is 4 cycles.
REQ-036 SHALL cover STOP: IDLE_VAL=0xFF, STOP mid-RUN -> dout=0xFF next cycle and BUSY=0; START+STOP in one write -> IDLE.
REQ-037 SHALL cover restart: START during step 1 -> dout=pattern[0] next cycle and step index 0.
REQ-038 SHALL cover dwell 0: dwell=0 -> step lasts PRESC+1 cycles; a write to addr 0x1F reads 0 and changes no state.
REQ-039 SHALL cover reset mid-RUN: assert reset_n=0 mid-RUN -> dout=0, STATUS=0 and all registers read 0 immediately.

Source files
------------

// File: rtl/gpo_seq_pkg.sv
// gpo_seq_pkg: shared definitions for the general-purpose output sequencer.
//   - slot register address map
//   - CTRL and STATUS bit positions
//   - FSM state encoding
//   - helper that maps a programmed dwell to the dwell actually used
package gpo_seq_pkg;

   localparam logic [4:0] ADDR_CTRL     = 5'h08;
   localparam logic [4:0] ADDR_PRESC    = 5'h09;
   localparam logic [4:0] ADDR_STATUS   = 5'h0A;
   localparam logic [4:0] ADDR_IDLE_VAL = 5'h0B;

   localparam int CTRL_START    = 0;
   localparam int CTRL_STOP     = 1;
   localparam int CTRL_LOOP     = 2;
   localparam int CTRL_LAST_LSB = 4;

   localparam int STAT_BUSY     = 0;
   localparam int STAT_DONE     = 1;
   localparam int STAT_STEP_LSB = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // A programmed dwell of zero is treated as a single tick.
   function automatic logic [15:0] eff_dwell(input logic [15:0] d);
      return (d == 16'd0) ? 16'd1 : d;
   endfunction

endpackage

// File: rtl/gpo_tick_gen.sv
// gpo_tick_gen: prescaler producing one tick every presc+1 clock cycles.
// Ports:
//   clk, reset_n : clock and asynchronous active-low reset
//   clear        : holds the counter at zero and suppresses the tick
//   presc[15:0]  : division value (tick period is presc+1 cycles)
//   tick         : one-cycle pulse
module gpo_tick_gen (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        clear,
   input  logic [15:0] presc,
   output logic        tick
);

   logic [15:0] cnt_q;

   // >= rather than == so that lowering presc mid-count cannot stall the
   // counter until it wraps.
   assign tick = !clear && (cnt_q >= presc);

   // NOTE: state registers use non-blocking assignments so every flop
   // samples pre-edge values, independent of process ordering.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else if (clear || tick) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 16'd1;
      end
   end

endmodule

// File: rtl/gpo_seq.sv
// gpo_seq: pattern sequencer driving a registered W-bit output from an
// 8-step table of {pattern, dwell} entries, paced by a prescaled tick.
// Ports:
//   clk, reset_n        : clock and asynchronous active-low reset
//   cs, read, write     : slot strobes (only cs && write has an effect)
//   addr[4:0]           : register address
//   wr_data[31:0]       : write data
//   rd_data[31:0]       : combinational read data selected by addr
//   dout[W-1:0]         : registered sequenced output
module gpo_seq
   import gpo_seq_pkg::*;
#(
   parameter int W     = 8,
   parameter int DEPTH = 8
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          cs,
   input  logic          read,
   input  logic          write,
   input  logic [4:0]    addr,
   input  logic [31:0]   wr_data,
   output logic [31:0]   rd_data,
   output logic [W-1:0]  dout
);

   // ---------------------------------------------------------------- decode
   logic wr_en, wr_step, ctrl_wr, start_wr, stop_wr, presc_wr, idle_wr;

   assign wr_en    = cs && write;
   assign wr_step  = wr_en && (addr < 5'(DEPTH));
   assign ctrl_wr  = wr_en && (addr == ADDR_CTRL);
   assign presc_wr = wr_en && (addr == ADDR_PRESC);
   assign idle_wr  = wr_en && (addr == ADDR_IDLE_VAL);
   assign start_wr = ctrl_wr && wr_data[CTRL_START];
   assign stop_wr  = ctrl_wr && wr_data[CTRL_STOP];

   // Reads have no side effects, so the read strobe is not needed.
   logic unused_read;
   assign unused_read = read;

   // ------------------------------------------------------------- registers
   logic [W-1:0] pat_q       [DEPTH];
   logic [15:0]  dwell_tab_q [DEPTH];
   logic         loop_q;
   logic [2:0]   last_q;
   logic [15:0]  presc_q;
   logic [W-1:0] idle_val_q;

   // NOTE: the table is reset explicitly because cleared contents are
   // architecturally visible through readback; this keeps it in flops.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            pat_q[i]       <= '0;
            dwell_tab_q[i] <= '0;
         end
      end else if (wr_step) begin
         pat_q[addr[2:0]]       <= wr_data[W-1:0];
         dwell_tab_q[addr[2:0]] <= wr_data[31:16];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         loop_q     <= 1'b0;
         last_q     <= '0;
         presc_q    <= '0;
         idle_val_q <= '0;
      end else begin
         if (ctrl_wr) begin
            loop_q <= wr_data[CTRL_LOOP];
            last_q <= wr_data[CTRL_LAST_LSB +: 3];
         end
         if (presc_wr) presc_q    <= wr_data[15:0];
         if (idle_wr)  idle_val_q <= wr_data[W-1:0];
      end
   end

   // ------------------------------------------------------------- prescaler
   state_t state_q, state_d;
   logic   tick, tick_clear;

   // Restart the prescaler on any START/STOP so the first tick of a run
   // arrives exactly presc+1 cycles after entry to step 0.
   assign tick_clear = (state_q != ST_RUN) || start_wr || stop_wr;

   gpo_tick_gen u_tick (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (tick_clear),
      .presc   (presc_q),
      .tick    (tick)
   );

   // ------------------------------------------------------------------- FSM
   logic [2:0]   step_q, step_d;
   logic [15:0]  dwell_q;
   logic         done_q, done_d;
   logic [W-1:0] dout_q, dout_d;
   logic         enter_step;
   logic         step_end;

   assign step_end = (state_q == ST_RUN) && tick && (dwell_q == 16'd1);

   // NOTE: every signal assigned here gets a default first, so no path
   // leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d    = state_q;
      step_d     = step_q;
      done_d     = done_q;
      enter_step = 1'b0;

      if (stop_wr) begin
         state_d = ST_IDLE;
      end else if (start_wr) begin
         state_d    = ST_RUN;
         step_d     = '0;
         done_d     = 1'b0;
         enter_step = 1'b1;
      end else if (step_end) begin
         if (step_q < last_q) begin
            step_d     = step_q + 3'd1;
            enter_step = 1'b1;
         end else if (loop_q) begin
            step_d     = '0;
            enter_step = 1'b1;
         end else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
         end
      end

      // Pattern and dwell are latched at step entry, so later table writes
      // only take effect at the next entry. IDLE follows IDLE_VAL, bypassing
      // a same-cycle write so the new value appears on the very next edge.
      dout_d = dout_q;
      if (enter_step) begin
         dout_d = pat_q[step_d];
      end else if (state_d == ST_IDLE) begin
         dout_d = idle_wr ? wr_data[W-1:0] : idle_val_q;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         step_q  <= '0;
         dwell_q <= '0;
         done_q  <= 1'b0;
         dout_q  <= '0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         done_q  <= done_d;
         dout_q  <= dout_d;
         if (enter_step) begin
            dwell_q <= eff_dwell(dwell_tab_q[step_d]);
         end else if ((state_q == ST_RUN) && tick) begin
            dwell_q <= dwell_q - 16'd1;
         end
      end
   end

   assign dout = dout_q;

   // -------------------------------------------------------------- readback
   always_comb begin
      rd_data = '0;
      if (addr < 5'(DEPTH)) begin
         rd_data = {dwell_tab_q[addr[2:0]], 16'h0000} | 32'(pat_q[addr[2:0]]);
      end else begin
         case (addr)
            ADDR_CTRL: begin
               rd_data[CTRL_LOOP]          = loop_q;
               rd_data[CTRL_LAST_LSB +: 3] = last_q;
            end
            ADDR_PRESC:    rd_data[15:0] = presc_q;
            ADDR_STATUS: begin
               rd_data[STAT_BUSY]          = (state_q == ST_RUN);
               rd_data[STAT_DONE]          = done_q;
               rd_data[STAT_STEP_LSB +: 3] = step_q;
            end
            ADDR_IDLE_VAL: rd_data = 32'(idle_val_q);
            default:       rd_data = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_gpo_seq.sv
// tb_gpo_seq: self-checking bench for gpo_seq (W=8). Register readback is
// table-driven; multi-cycle behaviour uses hand-written sequences and a
// randomized run compared against an expected-output queue built from the
// table contents.
module tb_gpo_seq;

   localparam logic [4:0] A_CTRL = 5'h08, A_PRESC = 5'h09,
                          A_STAT = 5'h0A, A_IDLE  = 5'h0B;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        cs, read, write;
   logic [4:0]  addr;
   logic [31:0] wr_data, rd_data;
   logic [7:0]  dout;

   int n_tests = 0;
   int n_fail  = 0;

   gpo_seq #(.W(8), .DEPTH(8)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .cs      (cs),
      .read    (read),
      .write   (write),
      .addr    (addr),
      .wr_data (wr_data),
      .rd_data (rd_data),
      .dout    (dout)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Write: drive after a falling edge, captured on the rising edge, and
   // return on the following falling edge.
   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      @(negedge clk);
      cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
      @(negedge clk);
      cs = 1'b0; write = 1'b0; wr_data = '0;
   endtask

   task automatic rd(input logic [4:0] a, output logic [31:0] d);
      cs = 1'b1; read = 1'b1; addr = a;
      #1;
      d = rd_data;
      cs = 1'b0; read = 1'b0;
   endtask

   task automatic check_reg(input string name, input logic [4:0] a, input logic [31:0] exp);
      logic [31:0] v;
      rd(a, v);
      check(name, v, exp);
   endtask

   task automatic setup_basic();
      wr(5'h00, 32'h0002_00A5);
      wr(5'h01, 32'h0003_003C);
      wr(A_PRESC, 32'h0000_0000);
      wr(A_CTRL, 32'h0000_0010);
   endtask

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;

   vec_t        vecs[8];
   logic [7:0]  r_pat[8];
   logic [15:0] r_dw[8];
   logic [7:0]  expq[$];

   initial begin
      logic [31:0] v;
      int presc, last, n;

      reset_n = 1'b0; cs = 1'b0; read = 1'b0; write = 1'b0;
      addr = '0; wr_data = '0;
      repeat (2) @(negedge clk);
      check("reset dout", 32'(dout), 32'h0);
      check_reg("reset status", A_STAT, 32'h0);
      check_reg("reset ctrl", A_CTRL, 32'h0);
      reset_n = 1'b1;

      // ---------------- register readback table
      vecs[0] = '{5'h00,  32'h1234_56A5, 32'h1234_00A5};
      vecs[1] = '{5'h07,  32'hFFFF_FFFF, 32'hFFFF_00FF};
      vecs[2] = '{A_CTRL, 32'hFFFF_FF74, 32'h0000_0074};
      vecs[3] = '{A_PRESC,32'hABCD_1234, 32'h0000_1234};
      vecs[4] = '{A_IDLE, 32'hFFFF_FF5A, 32'h0000_005A};
      vecs[5] = '{A_STAT, 32'hFFFF_FFFF, 32'h0000_0000};
      vecs[6] = '{5'h0C,  32'hFFFF_FFFF, 32'h0000_0000};
      vecs[7] = '{5'h1F,  32'hFFFF_FFFF, 32'h0000_0000};
      foreach (vecs[i]) begin
         wr(vecs[i].addr, vecs[i].wdata);
         check_reg($sformatf("regtab[%0d] status idle", i), A_STAT, 32'h0);
      end
      foreach (vecs[i]) begin
         rd(vecs[i].addr, v);
         check($sformatf("readback addr 0x%02h", vecs[i].addr), v, vecs[i].exp);
      end
      check("idle dout tracks idle_val", 32'(dout), 32'h5A);

      // ---------------- basic sequence
      setup_basic();
      wr(A_CTRL, 32'h0000_0011);
      begin
         logic [7:0] exp_seq[5];
         exp_seq = '{8'hA5, 8'hA5, 8'h3C, 8'h3C, 8'h3C};
         for (int k = 0; k < 5; k++) begin
            check($sformatf("basic dout[%0d]", k), 32'(dout), 32'(exp_seq[k]));
            check_reg($sformatf("basic busy[%0d]", k), A_STAT,
                      (k < 2) ? 32'h01 : 32'h11);
            @(negedge clk);
         end
      end
      check("basic done dout", 32'(dout), 32'h3C);
      check_reg("basic done status", A_STAT, 32'h12);
      repeat (3) @(negedge clk);
      check("basic done hold", 32'(dout), 32'h3C);

      // STOP from DONE keeps DONE sticky
      wr(A_CTRL, 32'h0000_0012);
      check("stop-from-done dout", 32'(dout), 32'h5A);
      check_reg("stop-from-done status", A_STAT, 32'h12);

      // ---------------- looping, LAST=0
      wr(5'h00, 32'h0001_0055);
      wr(A_PRESC, 32'h0000_0003);
      wr(A_CTRL, 32'h0000_0005);
      for (int k = 0; k < 20; k++) begin
         check_reg("loop status", A_STAT, 32'h01);
         check("loop dout", 32'(dout), 32'h55);
         @(negedge clk);
      end
      // tick period visible with two alternating single-tick steps
      wr(5'h00, 32'h0001_0011);
      wr(5'h01, 32'h0001_0022);
      wr(A_CTRL, 32'h0000_0015);
      for (int k = 0; k < 24; k++) begin
         check($sformatf("loop period dout[%0d]", k), 32'(dout),
               (((k / 4) % 2) != 0) ? 32'h22 : 32'h11);
         @(negedge clk);
      end

      // ---------------- STOP
      wr(A_CTRL, 32'h0000_0002);
      wr(A_IDLE, 32'h0000_00FF);
      check("idle_val write in idle", 32'(dout), 32'hFF);
      setup_basic();
      wr(A_CTRL, 32'h0000_0011);
      @(negedge clk);
      wr(A_CTRL, 32'h0000_0012);
      check("stop dout", 32'(dout), 32'hFF);
      rd(A_STAT, v);
      check("stop busy", 32'(v[1:0]), 32'h0);
      wr(A_CTRL, 32'h0000_0011);
      check("restart after stop dout", 32'(dout), 32'hA5);
      wr(A_CTRL, 32'h0000_0013);
      check("start+stop dout", 32'(dout), 32'hFF);
      rd(A_STAT, v);
      check("start+stop busy", 32'(v[0]), 32'h0);

      // ---------------- restart during step 1
      wr(A_CTRL, 32'h0000_0011);
      @(negedge clk);
      @(negedge clk);
      check("restart pre dout", 32'(dout), 32'h3C);
      wr(A_CTRL, 32'h0000_0011);
      check("restart dout", 32'(dout), 32'hA5);
      check_reg("restart status", A_STAT, 32'h01);

      // ---------------- dwell 0 and unmapped write
      wr(5'h00, 32'h0000_0011);
      wr(5'h01, 32'h0001_0022);
      wr(A_PRESC, 32'h0000_0002);
      wr(A_CTRL, 32'h0000_0011);
      for (int k = 0; k < 6; k++) begin
         check($sformatf("dwell0 dout[%0d]", k), 32'(dout), (k < 3) ? 32'h11 : 32'h22);
         @(negedge clk);
      end
      check_reg("dwell0 done status", A_STAT, 32'h12);
      wr(5'h1F, 32'hFFFF_FFFF);
      check_reg("unmapped reads 0", 5'h1F, 32'h0);
      check_reg("unmapped keeps presc", A_PRESC, 32'h2);
      check_reg("unmapped keeps ctrl", A_CTRL, 32'h10);
      check_reg("unmapped keeps idle", A_IDLE, 32'hFF);
      check_reg("unmapped keeps status", A_STAT, 32'h12);
      check_reg("unmapped keeps entry0", 5'h00, 32'h0000_0011);

      // ---------------- randomized sequences vs expected-output queue
      for (int r = 0; r < 24; r++) begin
         presc = $urandom_range(0, 3);
         last  = $urandom_range(0, 7);
         for (int s = 0; s < 8; s++) begin
            r_pat[s] = 8'($urandom);
            r_dw[s]  = 16'($urandom_range(0, 3));
            wr(5'(s), {r_dw[s], 8'h00, r_pat[s]});
         end
         wr(A_PRESC, {16'($urandom), 16'(presc)});
         expq.delete();
         for (int s = 0; s <= last; s++) begin
            n = ((r_dw[s] == 16'd0) ? 1 : int'(r_dw[s])) * (presc + 1);
            repeat (n) expq.push_back(r_pat[s]);
         end
         wr(A_CTRL, 32'(last) << 4);
         wr(A_CTRL, (32'(last) << 4) | 32'h1);
         foreach (expq[k]) begin
            check($sformatf("rand run %0d cycle %0d dout", r, k), 32'(dout), 32'(expq[k]));
            @(negedge clk);
         end
         check($sformatf("rand run %0d done dout", r), 32'(dout), 32'(r_pat[last]));
         check_reg($sformatf("rand run %0d status", r), A_STAT, (32'(last) << 4) | 32'h2);
      end

      // ---------------- reset mid-RUN
      setup_basic();
      wr(A_IDLE, 32'h0000_0077);
      wr(A_CTRL, 32'h0000_0011);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("midrun reset dout", 32'(dout), 32'h0);
      for (int a = 0; a < 12; a++) begin
         check_reg($sformatf("midrun reset reg 0x%02h", a), 5'(a), 32'h0);
      end
      @(negedge clk);
      reset_n = 1'b1;
      repeat (6) @(negedge clk);
      check("post reset dout", 32'(dout), 32'h0);
      check_reg("post reset status", A_STAT, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
